babbage_reader: RTL and testbench

BABBAGE_READER -- requirements
Module: babbage_reader

---
 rtl/babbage_reader_if.sv | 28 ++
 rtl/babbage_reader.sv | 178 +++++++++++++++++
 tb/tb_babbage_reader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/babbage_reader_if.sv
// Bundle between the difference-engine reader and its client: run control,
// engine pulses and captured term/differences.
interface babbage_reader_if;
  logic       go;
  logic [4:0] count;
  logic [9:0] indata;
  logic       start;
  logic       nextn;
  logic [9:0] value;
  logic [9:0] d1;
  logic [9:0] d2;
  logic [9:0] d3;
  logic [4:0] idx;
  logic       valid;
  logic       err;
  logic       busy;
  logic       done;

  modport master (
    output go, count, indata,
    input  start, nextn, value, d1, d2, d3, idx, valid, err, busy, done
  );

  modport slave (
    input  go, count, indata,
    output start, nextn, value, d1, d2, d3, idx, valid, err, busy, done
  );
endinterface

// File: rtl/babbage_reader.sv
// Reads successive terms from a difference engine via active-low start/next
// pulses and checks that the third difference stays constant.
module babbage_reader #(
  parameter int         PULSE_W = 2,
  parameter int         SETTLE  = 4,
  parameter logic [9:0] D3_EXP  = 10'd6
) (
  input  logic             clk,
  input  logic             rst,
  babbage_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, START_LO, START_SET, SAMPLE, NEXT_LO, NEXT_SET, DONE
  } state_t;

  localparam int CMAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    count_reg;
  logic [4:0]    k_reg;
  logic [4:0]    idx_reg;
  logic          err_reg;
  logic          start_reg, start_next;
  logic          nextn_reg, nextn_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          valid_reg, valid_next;
  logic          last_term;
  logic          first_term;
  logic          sample;

  assign last_term  = ({1'b0, k_reg} + 6'd1) >= {1'b0, count_reg};
  assign first_term = (k_reg == 5'd0);
  assign sample     = (state_reg == SAMPLE);

  // State register plus the registered outputs, so start/nextn never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      start_reg <= 1'b1;
      nextn_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
      nextn_reg <= nextn_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.go) begin
          state_next = (bus.count != 5'd0) ? START_LO : DONE;
        end
      end
      START_LO: begin
        if (cnt_reg == PW_LAST) begin
          state_next = START_SET;
          cnt_next   = '0;
        end
      end
      START_SET: begin
        if (cnt_reg == ST_LAST) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end
      end
      SAMPLE: begin
        cnt_next   = '0;
        state_next = last_term ? DONE : NEXT_LO;
      end
      NEXT_LO: begin
        if (cnt_reg == PW_LAST) begin
          state_next = NEXT_SET;
          cnt_next   = '0;
        end
      end
      NEXT_SET: begin
        if (cnt_reg == ST_LAST) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it.
  always_comb begin
    start_next = (state_next != START_LO);
    nextn_next = (state_next != NEXT_LO);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
    valid_next = sample;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      k_reg     <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.go) begin
        count_reg <= bus.count;
        k_reg     <= '0;
        err_reg   <= 1'b0;
      end
      if (sample) begin
        idx_reg <= k_reg;
        if (k_reg >= 5'd3 && g_diff[3].dn != D3_EXP) begin
          err_reg <= 1'b1;
        end
        if (!last_term) begin
          k_reg <= k_reg + 5'd1;
        end
      end
    end
  end

  // Stage 0 is the term itself; stage n is the n-th difference. The registered
  // value of each stage doubles as the history for the next term.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_diff
      logic [9:0] dn;
      logic [9:0] dr;
      if (gi == 0) begin : g_first
        assign dn = bus.indata;
      end else begin : g_rest
        assign dn = g_diff[gi-1].dn - (first_term ? 10'd0 : g_diff[gi-1].dr);
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dr <= '0;
        end else if (sample) begin
          dr <= dn;
        end
      end
    end
  endgenerate

  assign bus.start = start_reg;
  assign bus.nextn = nextn_reg;
  assign bus.value = g_diff[0].dr;
  assign bus.d1    = g_diff[1].dr;
  assign bus.d2    = g_diff[2].dr;
  assign bus.d3    = g_diff[3].dr;
  assign bus.idx   = idx_reg;
  assign bus.valid = valid_reg;
  assign bus.err   = err_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_babbage_reader.sv
// Bench for babbage_reader: a behavioural difference engine computing
// f(k)=k^3+5k^2+9k+6 (optionally corrupting one term) feeds the reader.
module tb_babbage_reader;
  localparam int         PW = 2;
  localparam int         ST = 4;
  localparam int         L  = 1 + PW + ST;
  localparam logic [9:0] D3 = 10'd6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  babbage_reader_if bus();

  babbage_reader #(.PULSE_W(PW), .SETTLE(ST), .D3_EXP(D3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int poly(input int k);
    return k * k * k + 5 * k * k + 9 * k + 6;
  endfunction

  // Engine: start low rewinds to term 0, each falling nextn advances a term.
  int   eng_term;
  logic nextn_d;
  int   bad_k = -1;
  int   bad_delta = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_term <= 0;
      nextn_d  <= 1'b1;
    end else begin
      nextn_d <= bus.nextn;
      if (!bus.start) eng_term <= 0;
      else if (nextn_d && !bus.nextn) eng_term <= eng_term + 1;
    end
  end
  always_comb bus.indata = 10'(poly(eng_term) + ((eng_term == bad_k) ? bad_delta : 0));

  // Monitor
  logic [9:0] q_val[$], q_d1[$], q_d2[$], q_d3[$];
  logic [4:0] q_idx[$];
  logic       q_err[$];
  int         q_cyc[$];
  int done_cnt = 0, done_cyc = 0, start_low = 0, nextn_low = 0, overlap = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid) begin
        q_val.push_back(bus.value); q_d1.push_back(bus.d1);
        q_d2.push_back(bus.d2);     q_d3.push_back(bus.d3);
        q_idx.push_back(bus.idx);   q_err.push_back(bus.err);
        q_cyc.push_back(cyc);
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (!bus.start) start_low++;
      if (!bus.nextn) nextn_low++;
      if (!bus.start && !bus.nextn) overlap++;
    end
  end

  // Reference model: term sequence and its difference tables.
  logic [9:0] m_val[32], m_d1[32], m_d2[32], m_d3[32];
  bit         m_err[32];
  function automatic void build_model(input int n, input int bk, input int delta);
    for (int k = 0; k < n; k++) begin
      m_val[k] = 10'(poly(k) + ((k == bk) ? delta : 0));
      m_d1[k]  = m_val[k] - ((k > 0) ? m_val[k-1] : 10'd0);
      m_d2[k]  = m_d1[k]  - ((k > 0) ? m_d1[k-1]  : 10'd0);
      m_d3[k]  = m_d2[k]  - ((k > 0) ? m_d2[k-1]  : 10'd0);
      m_err[k] = ((k > 0) && m_err[k-1]) || (k >= 3 && m_d3[k] != D3);
    end
  endfunction

  task automatic clear_capture();
    q_val.delete(); q_d1.delete(); q_d2.delete(); q_d3.delete();
    q_idx.delete(); q_err.delete(); q_cyc.delete();
    done_cnt = 0; start_low = 0; nextn_low = 0; overlap = 0;
  endtask

  // One complete run with per-term comparison against the model.
  task automatic run_scenario(input string name, input int n, input int bk,
                              input int delta, input bit poke);
    int go_edge;
    int sz;
    int exp_cyc;
    bad_k = bk; bad_delta = delta;
    build_model(n, bk, delta);
    clear_capture();
    bus.go = 1'b1; bus.count = 5'(n); go_edge = cyc + 1;
    @(posedge clk); #1;
    bus.go = 1'b0; bus.count = 5'($urandom);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      bus.go = (poke && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.count = 5'($urandom);
      @(posedge clk); #1;
    end
    bus.go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s done_count got %0d exp 1", name, done_cnt);
    end
    checks++;
    if (q_val.size() != n) begin
      errors++; $display("FAIL %s valid_count got %0d exp %0d", name, q_val.size(), n);
    end
    sz = (q_val.size() < n) ? q_val.size() : n;
    for (int k = 0; k < sz; k++) begin
      checks++;
      if (q_val[k] !== m_val[k]) begin
        errors++; $display("FAIL %s value[%0d] got %0d exp %0d", name, k, q_val[k], m_val[k]);
      end
      checks++;
      if ({q_d1[k], q_d2[k], q_d3[k]} !== {m_d1[k], m_d2[k], m_d3[k]}) begin
        errors++;
        $display("FAIL %s diffs[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", name, k,
                 q_d1[k], q_d2[k], q_d3[k], m_d1[k], m_d2[k], m_d3[k]);
      end
      checks++;
      if (q_idx[k] !== 5'(k)) begin
        errors++; $display("FAIL %s idx[%0d] got %0d exp %0d", name, k, q_idx[k], k);
      end
      checks++;
      if (q_err[k] !== m_err[k]) begin
        errors++; $display("FAIL %s err[%0d] got %0d exp %0d", name, k, q_err[k], m_err[k]);
      end
      exp_cyc = ((k == 0) ? go_edge : q_cyc[k-1]) + L;
      checks++;
      if (q_cyc[k] != exp_cyc) begin
        errors++; $display("FAIL %s valid_cycle[%0d] got %0d exp %0d", name, k, q_cyc[k], exp_cyc);
      end
    end
    checks++;
    if (done_cyc != go_edge + n * L) begin
      errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc, go_edge + n * L);
    end
    checks++;
    if (start_low != ((n > 0) ? PW : 0) || nextn_low != ((n > 0) ? (n - 1) * PW : 0)) begin
      errors++;
      $display("FAIL %s pulse_cycles got start=%0d nextn=%0d exp start=%0d nextn=%0d", name,
               start_low, nextn_low, (n > 0) ? PW : 0, (n > 0) ? (n - 1) * PW : 0);
    end
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL %s overlap got %0d exp 0", name, overlap);
    end
    if (n > 0) begin
      checks++;
      if (bus.value !== m_val[n-1] || bus.err !== m_err[n-1] || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s held got value=%0d err=%0d busy=%0d exp value=%0d err=%0d busy=0",
                 name, bus.value, bus.err, bus.busy, m_val[n-1], m_err[n-1]);
      end
    end
    $display("run %s count=%0d valids=%0d done=%0d", name, n, q_val.size(), done_cnt);
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.count = 5'd0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.start, bus.nextn, bus.valid, bus.err, bus.busy, bus.done} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 110000",
               {bus.start, bus.nextn, bus.valid, bus.err, bus.busy, bus.done});
    end
    checks++;
    if ({bus.value, bus.d1, bus.d2, bus.d3, bus.idx} !== 45'd0) begin
      errors++;
      $display("FAIL reset_data got value=%0d d1=%0d d2=%0d d3=%0d idx=%0d exp 0",
               bus.value, bus.d1, bus.d2, bus.d3, bus.idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.start, bus.nextn, bus.busy} !== 3'b110) begin
      errors++; $display("FAIL idle_after_reset got %b exp 110", {bus.start, bus.nextn, bus.busy});
    end
  endtask

  task automatic test_nominal();
    run_scenario("nominal", 5, -1, 0, 1'b0);
    checks++;
    if ({bus.value, bus.d1, bus.d2, bus.d3, bus.err} !== {10'd186, 10'd81, 10'd28, 10'd6, 1'b0}) begin
      errors++;
      $display("FAIL nominal_last got %0d/%0d/%0d/%0d err=%0d exp 186/81/28/6 err=0",
               bus.value, bus.d1, bus.d2, bus.d3, bus.err);
    end
  endtask

  task automatic test_wrap();
    run_scenario("wrap", 10, -1, 0, 1'b0);
    checks++;
    if ({bus.value, bus.d1, bus.err} !== {10'd197, 10'd311, 1'b0}) begin
      errors++;
      $display("FAIL wrap_last got value=%0d d1=%0d err=%0d exp 197/311/0", bus.value, bus.d1, bus.err);
    end
  endtask

  task automatic test_bad_term();
    bit seen;
    run_scenario("bad_term", 5, 3, 1, 1'b0);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL bad_term_held got err=%0d exp 1", bus.err);
    end
    bad_k = -1;
    clear_capture();
    bus.go = 1'b1; bus.count = 5'd3;
    @(posedge clk); #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL err_cleared_by_go got %0d exp 0", bus.err);
    end
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (done_cnt > 0);
    end
    checks++;
    if (!seen || bus.err !== 1'b0 || bus.value !== 10'd52) begin
      errors++;
      $display("FAIL clean_rerun got done=%0d err=%0d value=%0d exp 1/0/52", seen, bus.err, bus.value);
    end
  endtask

  task automatic test_zero_count();
    run_scenario("zero_count", 0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_scenario("busy_go_a", 5, -1, 0, 1'b1);
    run_scenario("busy_go_b", 7, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit found;
    bad_k = -1;
    clear_capture();
    bus.go = 1'b1; bus.count = 5'd5;
    @(posedge clk); #1;
    bus.go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk); #2;
      found = (bus.idx == 5'd1 && !bus.nextn);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_reach got 0 exp 1");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.start, bus.nextn, bus.valid, bus.err, bus.busy, bus.done} !== 6'b110000 ||
        {bus.value, bus.d1, bus.d2, bus.d3, bus.idx} !== 45'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got ctrl=%b value=%0d idx=%0d exp 110000/0/0",
               {bus.start, bus.nextn, bus.valid, bus.err, bus.busy, bus.done}, bus.value, bus.idx);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_done got done=%0d busy=%0d exp 0/0", done_cnt, bus.busy);
    end
    run_scenario("rerun_after_reset", 3, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int n, bk, delta;
    for (int it = 0; it < 10; it++) begin
      n     = $urandom_range(0, 14);
      bk    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 14) : -1;
      delta = $urandom_range(1, 1023);
      run_scenario($sformatf("random%0d", it), n, bk, delta, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.go = 1'b0;
    bus.count = 5'd0;
    test_reset();
    test_nominal();
    test_wrap();
    test_bad_term();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
